shl_flgs_pipe: RTL and testbench

- Two-stage pipelined logical/arithmetic shift-left (SHL/SAL) execution unit with x86 flag generation.
- Left-direction counterpart to the right-shift/SAR flag path in the execute stage.
- Operands are 8, 16 or 32 bits.
- Valid/ready handshake on both sides, so it can sit between the ALU issue latch and writeback with backpressure.

---
 rtl/shl_flgs_pipe.sv | 187 ++++++++++++++++++
 tb/tb_shl_flgs_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_flgs_pipe.sv
// shl_flgs_pipe: two-stage SHL/SAL execution unit with x86 flag generation and valid/ready handshake.
// Defining SHL_ROL_EN adds a rol_sel input that selects rotate-left within the operand size.
module shl_flgs_pipe #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       alu1_op_size,
`ifdef SHL_ROL_EN
  input  logic             rol_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [5:0]       flags,
  output logic [5:0]       flags_we,
  output logic             count_0
);

  typedef enum logic [1:0] {
    SZ8   = 2'b00,
    SZ16  = 2'b01,
    SZ32  = 2'b10,
    SZ32B = 2'b11
  } sizeE;

  logic        s1Valid_q;
  logic [32:0] s1E_q;
  sizeE        s1Size_q;
  logic        s1Count0_q;
  logic        s1Amt1_q;
  logic        s2Valid_q;
  logic [31:0] outData_q;
  logic [5:0]  flags_q;
  logic [5:0]  flagsWe_q;
  logic        count0_q;

  logic        s1Adv;
  logic        s2Adv;
  logic [31:0] opZx;
  logic [32:0] shl33;
  logic [32:0] eShl;
  logic [32:0] s1E_d;
  logic        s1Count0_d;
  logic        s1Amt1_d;

  logic [31:0] outData_d;
  logic        cfBit;
  logic        msbBit;
  logic        ofBit;
  logic [5:0]  flags_d;
  logic [5:0]  flagsWe_d;

  assign s2Adv    = !s2Valid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = s1Adv;

  // Stage 1: zero-extend to size and form E, whose bit at position "size" is the carry-out
  always_comb begin
    unique case (alu1_op_size)
      SZ8:     opZx = {24'd0, in_data[7:0]};
      SZ16:    opZx = {16'd0, in_data[15:0]};
      default: opZx = in_data[31:0];
    endcase
    shl33 = {1'b0, opZx} << in_amt;
    unique case (alu1_op_size)
      SZ8:     eShl = {24'd0, shl33[8:0]};
      SZ16:    eShl = {16'd0, shl33[16:0]};
      default: eShl = shl33;
    endcase
  end

`ifdef SHL_ROL_EN
  logic        s1Rol_q;
  logic [7:0]  rot8;
  logic [15:0] rot16;
  logic [31:0] rot32;
  logic [32:0] eRol;

  // Rotation places result[0] in the carry slot so stage 2 derives CF the same way as for SHL
  always_comb begin
    rot8  = 8'((opZx[7:0] << in_amt[2:0]) | (opZx[7:0] >> (4'd8 - {1'b0, in_amt[2:0]})));
    rot16 = 16'((opZx[15:0] << in_amt[3:0]) | (opZx[15:0] >> (5'd16 - {1'b0, in_amt[3:0]})));
    rot32 = 32'((opZx << in_amt) | (opZx >> (6'd32 - {1'b0, in_amt})));
    unique case (alu1_op_size)
      SZ8:     eRol = {24'd0, rot8[0], rot8};
      SZ16:    eRol = {16'd0, rot16[0], rot16};
      default: eRol = {rot32[0], rot32};
    endcase
    s1E_d = rol_sel ? eRol : eShl;
  end
`else
  assign s1E_d = eShl;
`endif

  assign s1Count0_d = (in_amt == AMT_W'(0));
  assign s1Amt1_d   = (in_amt == AMT_W'(1));

  // Stage 2: result and flags from the latched E
  always_comb begin
    unique case (s1Size_q)
      SZ8: begin
        outData_d = {24'd0, s1E_q[7:0]};
        cfBit     = s1E_q[8];
        msbBit    = s1E_q[7];
      end
      SZ16: begin
        outData_d = {16'd0, s1E_q[15:0]};
        cfBit     = s1E_q[16];
        msbBit    = s1E_q[15];
      end
      default: begin
        outData_d = s1E_q[31:0];
        cfBit     = s1E_q[32];
        msbBit    = s1E_q[31];
      end
    endcase
    ofBit   = s1Amt1_q & (msbBit ^ cfBit);
    flags_d = {ofBit, msbBit, (outData_d == 32'd0), 1'b0, ~^outData_d[7:0], cfBit};
    if (s1Count0_q) begin
      flagsWe_d = 6'b000000;
`ifdef SHL_ROL_EN
    end else if (s1Rol_q) begin
      flagsWe_d = 6'b100001;
`endif
    end else begin
      flagsWe_d = 6'b111111;
    end
  end

  // Both stages load only on their own advance, so a stalled output bundle stays frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1E_q      <= '0;
      s1Size_q   <= SZ8;
      s1Count0_q <= 1'b0;
      s1Amt1_q   <= 1'b0;
`ifdef SHL_ROL_EN
      s1Rol_q    <= 1'b0;
`endif
      s2Valid_q  <= 1'b0;
      outData_q  <= '0;
      flags_q    <= '0;
      flagsWe_q  <= '0;
      count0_q   <= 1'b0;
    end else begin
      if (s1Adv) begin
        s1Valid_q <= in_valid;
        if (in_valid) begin
          s1E_q      <= s1E_d;
          s1Size_q   <= sizeE'(alu1_op_size);
          s1Count0_q <= s1Count0_d;
          s1Amt1_q   <= s1Amt1_d;
`ifdef SHL_ROL_EN
          s1Rol_q    <= rol_sel;
`endif
        end
      end
      if (s2Adv) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          outData_q <= outData_d;
          flags_q   <= flags_d;
          flagsWe_q <= flagsWe_d;
          count0_q  <= s1Count0_q;
        end
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign out_data  = outData_q;
  assign flags     = flags_q;
  assign flags_we  = flagsWe_q;
  assign count_0   = count0_q;

  holdStable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(flags) &&
                                   $stable(flags_we) && $stable(count_0)));

endmodule

// File: tb/tb_shl_flgs_pipe.sv
// Randomized scoreboard bench for shl_flgs_pipe; a monitor checks every presented result
// against an arithmetic model of the shift/rotate rules, plus directed reset and backpressure checks.
module tb_shl_flgs_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  alu1_op_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  flags;
  logic [5:0]  flags_we;
  logic        count_0;
`ifdef SHL_ROL_EN
  logic        rolSel;
`endif

  int total = 0;
  int bad = 0;
  bit readyRandom = 1'b0;
  bit readyForce = 1'b1;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  flg;
    logic [5:0]  we;
    logic        c0;
  } expT;

  expT sb[$];

  always #5 clk = ~clk;

  shl_flgs_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_amt       (in_amt),
    .alu1_op_size (alu1_op_size),
`ifdef SHL_ROL_EN
    .rol_sel      (rolSel),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flags        (flags),
    .flags_we     (flags_we),
    .count_0      (count_0)
  );

  // Reference model: plain integer arithmetic on the operand width
  function automatic expT model(input logic [31:0] d, input int amt, input logic [1:0] s, input bit rol);
    expT e;
    int sz;
    int k;
    logic [63:0] mask;
    logic [63:0] op;
    logic [63:0] res;
    logic [63:0] wide;
    logic cf;
    logic msb;
    sz   = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
    mask = (64'd1 << sz) - 64'd1;
    op   = {32'd0, d} & mask;
    if (rol) begin
      k   = amt % sz;
      res = ((op << k) | (op >> (sz - k))) & mask;
      cf  = res[0];
    end else begin
      wide = op << amt;
      res  = wide & mask;
      cf   = wide[sz];
    end
    msb    = res[sz-1];
    e.data = res[31:0];
    e.flg  = {(amt == 1) ? (msb ^ cf) : 1'b0, msb, (res == 64'd0), 1'b0, ~^res[7:0], cf};
    e.we   = (amt == 0) ? 6'b000000 : (rol ? 6'b100001 : 6'b111111);
    e.c0   = (amt == 0);
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input expT e);
    total++;
    if (out_data !== e.data || flags_we !== e.we || count_0 !== e.c0 ||
        (flags & e.we) !== (e.flg & e.we)) begin
      bad++;
      $display("[TB] FAIL %s got data=%h flags=%b we=%b c0=%b want data=%h flags=%b we=%b c0=%b",
               tag, out_data, flags, flags_we, count_0, e.data, e.flg, e.we, e.c0);
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that accepted the bundle
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] a, input logic [1:0] s, input bit r);
    bit acc;
    bit effRol;
    int waited;
    acc = 1'b0;
    waited = 0;
`ifdef SHL_ROL_EN
    effRol = r;
    rolSel = r;
`else
    effRol = 1'b0;
`endif
    in_valid = 1'b1;
    in_data = d;
    in_amt = a;
    alu1_op_size = s;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d, int'(a), s, effRol));
        acc = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout got in_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkVal("drain_pending", sb.size(), 0);
  endtask

  // Output consumer: random or forced ready, updated just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyForce;
    end
  end

  // Monitor: a presented result must match the oldest expectation; it is retired on handshake
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output got data=%h want no pending result", out_data);
        end else if (out_ready) begin
          e = sb.pop_front();
          checkOutput("result", e);
        end else begin
          checkOutput("held", sb[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sz;
    int a;
    logic [1:0] s;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    alu1_op_size = '0;
`ifdef SHL_ROL_EN
    rolSel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", 32'(out_valid), 0);
    checkVal("rst_out_data", out_data, 0);
    checkVal("rst_flags", 32'(flags), 0);
    checkVal("rst_flags_we", 32'(flags_we), 0);
    checkVal("rst_count_0", 32'(count_0), 0);
    rst_n = 1'b1;
    #1;
    checkVal("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    applyStimulus(32'h000000C1, 5'd1, 2'b00, 1'b0);
    applyStimulus(32'h00008001, 5'd16, 2'b01, 1'b0);
    applyStimulus(32'h00008001, 5'd17, 2'b01, 1'b0);
    applyStimulus(32'h40000000, 5'd1, 2'b10, 1'b0);
    applyStimulus(32'h40000000, 5'd0, 2'b10, 1'b0);
    applyStimulus(32'hFFFFFFFF, 5'd31, 2'b11, 1'b0);
`ifdef SHL_ROL_EN
    applyStimulus(32'h00000081, 5'd1, 2'b00, 1'b1);
    applyStimulus(32'h00001234, 5'd20, 2'b01, 1'b1);
`endif
    waitDrain();

    $display("[TB] backpressure");
    readyForce = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h00000011, 5'd2, 2'b00, 1'b0);
    applyStimulus(32'h00002222, 5'd3, 2'b01, 1'b0);
    @(negedge clk);
    checkVal("bp_in_ready_low", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    fork
      begin
        applyStimulus(32'h33333333, 5'd4, 2'b10, 1'b0);
        applyStimulus(32'h00000044, 5'd5, 2'b00, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        readyForce = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] reset with both stages full");
    readyForce = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'h00000055, 5'd1, 2'b00, 1'b0);
    applyStimulus(32'h00000066, 5'd2, 2'b00, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("midrst_out_valid", 32'(out_valid), 0);
    checkVal("midrst_in_ready", 32'(in_ready), 1);
    sb.delete();
    readyForce = 1'b1;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h000000C1, 5'd1, 2'b00, 1'b0);
    @(negedge clk);
    checkVal("lat_cycle1_valid", 32'(out_valid), 0);
    @(negedge clk);
    checkVal("lat_cycle2_valid", 32'(out_valid), 1);
    checkVal("lat_cycle2_data", out_data, 32'h00000082);
    checkVal("lat_cycle2_flags", 32'(flags), 32'h13);
    checkVal("lat_cycle2_we", 32'(flags_we), 32'h3F);
    @(posedge clk);
    #1;
    waitDrain();

    $display("[TB] random traffic");
    readyRandom = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      s  = 2'($urandom_range(0, 3));
      sz = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
      case ($urandom_range(0, 5))
        0: a = 0;
        1: a = 1;
        2: a = sz - 1;
        3: a = sz;
        4: a = sz + 1;
        default: a = int'($urandom_range(0, 31));
      endcase
      applyStimulus($urandom, 5'(a), s, 1'($urandom_range(0, 1)));
    end
    readyRandom = 1'b0;
    readyForce = 1'b1;
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
